// File: rtl/mux16_pkg.sv
// mux16_pkg: shared sizes, state encoding and default hold limit for the mux16 arbiter
package mux16_pkg;
  localparam int NREQ = 16;
  localparam int SELW = 4;
  localparam int MAX_HOLD_DEF = 8;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: rotated priority scan over 16 requests, starting at ptr_i, optionally skipping mask_idx_i
// Ports: req_i requests, ptr_i scan start, mask_idx_i/mask_en_i excluded index, found_o any hit, idx_o winner
module rr_pick16
  import mux16_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic [SELW-1:0] mask_idx_i,
  input  logic            mask_en_i,
  output logic            found_o,
  output logic [SELW-1:0] idx_o
);
  logic [SELW-1:0] c;
  // Scanning from the far end lets the nearest hit to ptr_i overwrite later ones.
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    c = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = ptr_i + SELW'(k);
      if (req_i[c] && !(mask_en_i && c == mask_idx_i)) begin
        found_o = 1'b1;
        idx_o = c;
      end
    end
  end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner of the mux16 select with a fairness hold limit
// Ports: clk, rst_n (sync active-low), req_i requests, gnt_o one-hot grant, gnt_valid_o grant present,
//        sel_o owner index for mux16, busy_cycles_o consecutive cycles held (saturating)
module mux16_rr_arbiter
  import mux16_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            gnt_valid_o,
  output logic [SELW-1:0] sel_o,
  output logic [7:0]      busy_cycles_o
);
  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d, sel_q, sel_d, scan_ptr, idx;
  logic [NREQ-1:0] gnt_q, gnt_d, oh;
  logic [7:0]      busy_q, busy_d;
  logic            found, rel, pre;
  // While granted, the scan starts after the owner and skips it, so the same
  // pick serves release, preemption and the "anyone else waiting" test.
  assign scan_ptr = (state_q == GRANT) ? sel_q + 4'd1 : ptr_q;
  rr_pick16 u_pick (
    .req_i      (req_i),
    .ptr_i      (scan_ptr),
    .mask_idx_i (sel_q),
    .mask_en_i  (state_q == GRANT),
    .found_o    (found),
    .idx_o      (idx)
  );
  assign oh  = NREQ'(1) << idx;
  assign rel = (state_q == GRANT) && !req_i[sel_q];
  assign pre = (state_q == GRANT) && req_i[sel_q] && (busy_q >= 8'(MAX_HOLD)) && found;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    busy_d = busy_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = GRANT;
        gnt_d = oh;
        sel_d = idx;
        busy_d = 8'd1;
      end
    end else if (rel || pre) begin
      ptr_d = sel_q + 4'd1;
      state_d = found ? GRANT : IDLE;
      gnt_d = found ? oh : '0;
      sel_d = found ? idx : sel_q;
      busy_d = found ? 8'd1 : 8'd0;
    end else begin
      busy_d = (busy_q == 8'hFF) ? busy_q : busy_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      sel_q <= '0;
      busy_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      busy_q <= busy_d;
    end
  end
  assign gnt_o = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign sel_o = sel_q;
  assign busy_cycles_o = busy_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: scoreboard bench for mux16_rr_arbiter against a behavioural arbiter model
module tb_mux16_rr_arbiter;
  localparam int MH = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_i = '0;
  logic [15:0] gnt_o;
  logic        gnt_valid_o;
  logic [3:0]  sel_o;
  logic [7:0]  busy_cycles_o;
  int tests = 0;
  int fails = 0;
  logic [28:0] exp_q[$];
  int m_owner = -1;
  int m_ptr = 0;
  int m_busy = 0;
  int m_sel = 0;

  mux16_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .gnt_valid_o   (gnt_valid_o),
    .sel_o         (sel_o),
    .busy_cycles_o (busy_cycles_o)
  );

  always #5 clk = ~clk;

  function automatic int scan(logic [15:0] r, int p, int ex);
    for (int k = 0; k < 16; k++) begin
      int i;
      i = (p + k) % 16;
      if (r[i] && i != ex) return i;
    end
    return -1;
  endfunction

  function automatic void grant_to(int w);
    m_owner = w;
    m_sel = w;
    m_busy = 1;
  endfunction

  task automatic drive(input logic [15:0] r, input logic rn);
    logic [15:0] g;
    int o, other;
    @(negedge clk);
    req_i = r;
    rst_n = rn;
    if (!rn) begin
      m_owner = -1; m_ptr = 0; m_busy = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      other = scan(r, m_ptr, -1);
      if (other >= 0) grant_to(other);
    end else begin
      o = m_owner;
      other = scan(r, (o + 1) % 16, o);
      if (!r[o] || (m_busy >= MH && other >= 0)) begin
        m_ptr = (o + 1) % 16;
        if (other >= 0) grant_to(other);
        else begin
          m_owner = -1;
          m_busy = 0;
        end
      end else if (m_busy < 255) m_busy++;
    end
    g = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    exp_q.push_back({g, 4'(m_sel), m_owner >= 0, 8'(m_busy)});
  endtask

  initial begin
    logic [28:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({gnt_o, sel_o, gnt_valid_o, busy_cycles_o} !== e) begin
          fails++;
          $display("FAIL arb t=%0t: got gnt=%h sel=%0d valid=%b busy=%0d, want gnt=%h sel=%0d valid=%b busy=%0d",
                   $time, gnt_o, sel_o, gnt_valid_o, busy_cycles_o, e[28:13], e[12:9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [15:0] r;
    repeat (2) drive(16'h0000, 1'b0);
    repeat (4) drive(16'h0004, 1'b1);
    drive(16'h0004, 1'b0);
    repeat (2) drive(16'h0000, 1'b1);
    repeat (40) drive(16'h8001, 1'b1);
    drive(16'h0000, 1'b0);
    repeat (3) drive(16'h8000, 1'b1);
    repeat (3) drive(16'h0002, 1'b1);
    drive(16'h0000, 1'b1);
    repeat (300) drive(16'h0020, 1'b1);
    drive(16'h0000, 1'b0);
    repeat (40) drive((m_owner >= 0) ? (16'hFFFF & ~(16'd1 << m_owner)) : 16'hFFFF, 1'b1);
    drive(16'h0000, 1'b0);
    repeat (3) drive(16'h0008, 1'b1);
    drive(16'h0200, 1'b1);
    repeat (3) drive(16'h0208, 1'b1);
    repeat (3) drive(16'h0008, 1'b1);
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 16; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
      drive(r, $urandom_range(199) != 0);
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
